// File: rtl/rv_decode_stage.sv
// RV32I decode pipeline stage: takes a fetched instruction and PC, reads the
// register file combinationally and registers one decoded bundle for execute.
module rv_decode_stage #(
   parameter int XLEN    = 32,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_instr,
   input  logic [XLEN-1:0]    in_pc,
   input  logic               flush,
   output logic [4:0]         rf_raddr1,
   output logic [4:0]         rf_raddr2,
   input  logic [XLEN-1:0]    rf_rdata1,
   input  logic [XLEN-1:0]    rf_rdata2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [6:0]         out_opcode,
   output logic [4:0]         out_rd,
   output logic [4:0]         out_rs1,
   output logic [4:0]         out_rs2,
   output logic [2:0]         out_funct3,
   output logic [6:0]         out_funct7,
   output logic [XLEN-1:0]    out_pc,
   output logic [XLEN-1:0]    out_reg_a,
   output logic [XLEN-1:0]    out_reg_b,
   output logic [XLEN-1:0]    out_imm,
   output logic               out_rd_we,
   output logic               out_illegal,
   output logic [COUNT_W-1:0] decode_count
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0]      opcode;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            sign;
   logic            accept;
   logic            dec_writes;
   logic            dec_illegal;
   logic            dec_rd_we;
   logic [XLEN-1:0] dec_imm;

   assign opcode = in_instr[6:0];
   assign rd     = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign sign   = in_instr[31];

   assign rf_raddr1 = in_instr[19:15];
   assign rf_raddr2 = in_instr[24:20];

   // Handshake: a side transfers on a cycle where its valid and ready are both
   // high. in_ready depends only on out_valid/out_ready (never on in_valid), and
   // a held bundle stays frozen until out_ready is seen. flush kills both the
   // held bundle and any transfer in the same cycle.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      dec_imm     = '0;
      dec_writes  = 1'b0;
      dec_illegal = 1'b0;
      case (opcode)
         OP_REG: begin
            dec_writes = 1'b1;
            if (funct7 == F7_ALT) begin
               if (funct3 != 3'b000 && funct3 != 3'b101) dec_illegal = 1'b1;
            end else if (funct7 != F7_BASE) begin
               dec_illegal = 1'b1;
            end
         end
         OP_IMM: begin
            dec_writes = 1'b1;
            dec_imm    = {{(XLEN-12){sign}}, in_instr[31:20]};
            if (funct3 == 3'b001 && funct7 != F7_BASE) dec_illegal = 1'b1;
            if (funct3 == 3'b101 && funct7 != F7_BASE && funct7 != F7_ALT)
               dec_illegal = 1'b1;
         end
         OP_LOAD, OP_JALR: begin
            dec_writes = 1'b1;
            dec_imm    = {{(XLEN-12){sign}}, in_instr[31:20]};
         end
         OP_STORE: begin
            dec_imm = {{(XLEN-12){sign}}, in_instr[31:25], in_instr[11:7]};
         end
         OP_BRANCH: begin
            dec_imm = {{(XLEN-12){sign}}, in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            dec_writes = 1'b1;
            dec_imm    = {{(XLEN-32){sign}}, in_instr[31:12], 12'b0};
         end
         OP_JAL: begin
            dec_writes = 1'b1;
            dec_imm    = {{(XLEN-20){sign}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
         end
         default: dec_illegal = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11) dec_illegal = 1'b1;
      // Illegal encodings still flow downstream, but carry no immediate.
      if (dec_illegal) dec_imm = '0;
   end

   assign dec_rd_we = dec_writes && !dec_illegal && (rd != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_opcode   <= '0;
         out_rd       <= '0;
         out_rs1      <= '0;
         out_rs2      <= '0;
         out_funct3   <= '0;
         out_funct7   <= '0;
         out_pc       <= '0;
         out_reg_a    <= '0;
         out_reg_b    <= '0;
         out_imm      <= '0;
         out_rd_we    <= 1'b0;
         out_illegal  <= 1'b0;
         decode_count <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_opcode   <= opcode;
         out_rd       <= rd;
         out_rs1      <= in_instr[19:15];
         out_rs2      <= in_instr[24:20];
         out_funct3   <= funct3;
         out_funct7   <= funct7;
         out_pc       <= in_pc;
         out_reg_a    <= rf_rdata1;
         out_reg_b    <= rf_rdata2;
         out_imm      <= dec_imm;
         out_rd_we    <= dec_rd_we;
         out_illegal  <= dec_illegal;
         decode_count <= decode_count + COUNT_W'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: hand-decoded RV32I vectors, backpressure,
// flush, full-rate streaming and asynchronous reset.
module tb_rv_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic [4:0]  rf_raddr1;
   logic [4:0]  rf_raddr2;
   logic [31:0] rf_rdata1;
   logic [31:0] rf_rdata2;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_opcode;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic [31:0] out_pc;
   logic [31:0] out_reg_a;
   logic [31:0] out_reg_b;
   logic [31:0] out_imm;
   logic        out_rd_we;
   logic        out_illegal;
   logic [15:0] decode_count;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] exp_count = '0;

   // Hand-decoded vectors: lui, auipc, lw, jalr(ret), beq, sub, bad sub,
   // bad slli, srai, addi -1, nop, all-zero word.
   localparam int NV = 12;
   logic [31:0] v_instr [0:NV-1] = '{32'h123452B7, 32'hFFFFF097, 32'h00812283,
      32'h00008067, 32'hFE208EE3, 32'h402081B3, 32'h4020C1B3, 32'h02001093,
      32'h4030D093, 32'hFFF00093, 32'h00000013, 32'h00000000};
   logic [31:0] v_imm [0:NV-1] = '{32'h12345000, 32'hFFFFF000, 32'h00000008,
      32'h00000000, 32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h00000403, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
   logic v_we  [0:NV-1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b0, 1'b0};
   logic v_ill [0:NV-1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                            1'b0, 1'b0, 1'b0, 1'b1};

   rv_decode_stage #(.XLEN(32), .COUNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_funct7(out_funct7), .out_pc(out_pc),
      .out_reg_a(out_reg_a), .out_reg_b(out_reg_b), .out_imm(out_imm),
      .out_rd_we(out_rd_we), .out_illegal(out_illegal), .decode_count(decode_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] ra, input logic [31:0] rb);
      in_valid  = 1'b1;
      in_instr  = instr;
      in_pc     = pc;
      rf_rdata1 = ra;
      rf_rdata2 = rb;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
      rf_rdata1 = '0; rf_rdata2 = '0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(decode_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_imm", out_imm, 32'd0);
      step();
      rst_n = 1'b1;

      in_instr = 32'hFE20AE23;
      #1;
      chk("raddr1_comb", 32'(rf_raddr1), 32'd1);
      chk("raddr2_comb", 32'(rf_raddr2), 32'd2);

      // addi x1,x0,5
      drive(32'h00500093, 32'h100, 32'h0, 32'h0);
      step(); exp_count++;
      chk("addi_valid", 32'(out_valid), 32'd1);
      chk("addi_rd", 32'(out_rd), 32'd1);
      chk("addi_imm", out_imm, 32'h5);
      chk("addi_we", 32'(out_rd_we), 32'd1);
      chk("addi_ill", 32'(out_illegal), 32'd0);
      chk("addi_pc", out_pc, 32'h100);
      chk("addi_count", 32'(decode_count), 32'(exp_count));

      // sw x2,-4(x1)
      drive(32'hFE20AE23, 32'h104, 32'h1000, 32'hDEADBEEF);
      step(); exp_count++;
      chk("sw_imm", out_imm, 32'hFFFFFFFC);
      chk("sw_reg_a", out_reg_a, 32'h1000);
      chk("sw_reg_b", out_reg_b, 32'hDEADBEEF);
      chk("sw_we", 32'(out_rd_we), 32'd0);
      chk("sw_rs1", 32'(out_rs1), 32'd1);
      chk("sw_rs2", 32'(out_rs2), 32'd2);
      chk("sw_funct3", 32'(out_funct3), 32'd2);

      // jal x1,-8
      drive(32'hFF9FF0EF, 32'h108, 32'h0, 32'h0);
      step(); exp_count++;
      chk("jal_imm", out_imm, 32'hFFFFFFF8);
      chk("jal_we", 32'(out_rd_we), 32'd1);
      chk("jal_ill", 32'(out_illegal), 32'd0);

      // mul x3,x1,x2 (M extension, unsupported)
      drive(32'h022081B3, 32'h10C, 32'h0, 32'h0);
      step(); exp_count++;
      chk("mul_ill", 32'(out_illegal), 32'd1);
      chk("mul_we", 32'(out_rd_we), 32'd0);
      chk("mul_imm", out_imm, 32'd0);
      chk("mul_funct7", 32'(out_funct7), 32'h01);
      chk("mul_opcode", 32'(out_opcode), 32'h33);
      chk("mul_count", 32'(decode_count), 32'(exp_count));

      for (int i = 0; i < NV; i++) begin
         drive(v_instr[i], 32'h200 + 32'(i * 4), 32'(i), 32'h0);
         step(); exp_count++;
         chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_imm", i), out_imm, v_imm[i]);
         chk($sformatf("vec%0d_we", i), 32'(out_rd_we), 32'(v_we[i]));
         chk($sformatf("vec%0d_ill", i), 32'(out_illegal), 32'(v_ill[i]));
         chk($sformatf("vec%0d_reg_a", i), out_reg_a, 32'(i));
      end

      // Backpressure: last vector (pc 0x22C, illegal zero word) must stay frozen.
      out_ready = 1'b0;
      drive(32'h00700393, 32'h300, 32'h77, 32'h0);
      #1;
      chk("bp_in_ready_comb", 32'(in_ready), 32'd0);
      for (int c = 0; c < 3; c++) begin
         rf_rdata1 = 32'h55 + 32'(c);
         step();
         chk($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
         chk($sformatf("bp%0d_pc", c), out_pc, 32'h22C);
         chk($sformatf("bp%0d_ill", c), 32'(out_illegal), 32'd1);
         chk($sformatf("bp%0d_reg_a", c), out_reg_a, 32'd11);
         chk($sformatf("bp%0d_count", c), 32'(decode_count), 32'(exp_count));
      end
      out_ready = 1'b1;
      rf_rdata1 = 32'h77;
      step(); exp_count++;
      chk("bp_rel_rd", 32'(out_rd), 32'd7);
      chk("bp_rel_pc", out_pc, 32'h300);
      chk("bp_rel_imm", out_imm, 32'h7);
      chk("bp_rel_reg_a", out_reg_a, 32'h77);
      chk("bp_rel_count", 32'(decode_count), 32'(exp_count));
      in_valid = 1'b0;
      step();
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_count", 32'(decode_count), 32'(exp_count));

      // Flush with a held bundle and a new instruction offered.
      out_ready = 1'b0;
      drive(32'h00100113, 32'h400, 32'h0, 32'h0);
      step(); exp_count++;
      chk("pre_flush_valid", 32'(out_valid), 32'd1);
      drive(32'h00200193, 32'h404, 32'h0, 32'h0);
      flush = 1'b1;
      step();
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_count", 32'(decode_count), 32'(exp_count));
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      chk("post_flush_valid", 32'(out_valid), 32'd0);

      // Full-rate stream of five addi instructions.
      for (int k = 0; k < 5; k++) begin
         drive(32'h00000093 | (32'(k) << 20), 32'h500 + 32'(k * 4), 32'h0, 32'h0);
         step(); exp_count++;
         chk($sformatf("stream%0d_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("stream%0d_pc", k), out_pc, 32'h500 + 32'(k * 4));
         chk($sformatf("stream%0d_imm", k), out_imm, 32'(k));
         chk($sformatf("stream%0d_count", k), 32'(decode_count), 32'(exp_count));
      end

      // Asynchronous reset between clock edges while still streaming.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_count", 32'(decode_count), 32'd0);
      chk("async_rst_pc", out_pc, 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_count", 32'(decode_count), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage between fetch and execute.
- Accepts a fetched instruction and PC over a valid/ready handshake.
- Drives the register-file read addresses combinationally and captures read data.
- Presents one registered decoded bundle downstream: fields, full sign-extended immediate for every format, write-enable and illegal flag. Supports backpressure, flush and an accepted-instruction counter.

Parameters:
- XLEN, 32, data/PC width; immediates sign-extend to XLEN.
- COUNT_W, 16, width of the decoded-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  kill held and incoming instruction (branch redirect).
- rf_raddr1  out  5  equals in_instr[19:15], combinational.
- rf_raddr2  out  5  equals in_instr[24:20], combinational.
- rf_rdata1  in  XLEN  regfile data for rf_raddr1, same cycle.
- rf_rdata2  in  XLEN  regfile data for rf_raddr2, same cycle.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_opcode  out  7  instr[6:0].
- out_rd / out_rs1 / out_rs2  out  5 each  register fields.
- out_funct3  out  3  instr[14:12].
- out_funct7  out  7  instr[31:25].
- out_pc  out  XLEN  captured PC.
- out_reg_a / out_reg_b  out  XLEN each  captured rf_rdata1 / rf_rdata2.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd_we  out  1  instruction writes rd.
- out_illegal  out  1  unsupported encoding.
- decode_count  out  COUNT_W  instructions accepted since reset.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, every out_* = 0, decode_count=0. in_ready is 1 once out_valid=0.
  - Reset asserted mid-transfer discards the held bundle; no partial state survives.
- in_ready = !out_valid || out_ready, combinational. No combinational path from in_valid to in_ready.
- Accept when in_valid && in_ready && !flush. The bundle registers at that edge and out_valid=1 next cycle. Latency is 1 cycle.
- Pass-through at full rate: out_ready=1 sustains one instruction per cycle.
- Hold when out_valid && !out_ready. All out_* stay stable, in_ready=0, rf_rdata is not resampled.
- out_valid falls when out_ready is seen with no simultaneous accept.
- flush has priority over everything except reset.
  - Next cycle out_valid=0; any accept that cycle is dropped and not counted.
  - The out_* data fields may retain stale values.
- decode_count increments by 1 per accept, wraps modulo 2^COUNT_W, never counts flushed instructions.
- Immediate by opcode (sign bit is instr[31]):
  - I-type (0010011, 0000011, 1100111): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R-type and illegal: 0.
- out_rd_we = 1 for R, I, U and J opcodes with rd != 0. It is 0 for store, branch, illegal, or rd == 0.
- out_illegal = 1 when any of the following holds (the instruction still flows with rd_we=0):
  - opcode is not one of the nine listed;
  - opcode 0110011 with funct7 not in {0000000, 0100000};
  - opcode 0110011 with funct7=0100000 and funct3 not in {000, 101};
  - opcode 0010011 with funct3=001 and instr[31:25] != 0;
  - opcode 0010011 with funct3=101 and instr[31:25] not in {0000000, 0100000};
  - instr[1:0] != 11.

Test Plan:
- Reset then in_instr=0x00500093 (addi x1,x0,5), pc=0x100, rf_rdata1=0 → next cycle: out_valid=1, rd=1, imm=0x00000005, rd_we=1, illegal=0, decode_count=1.
- 0xFE20AE23 (sw x2,-4(x1)), rf_rdata1=0x1000, rf_rdata2=0xDEADBEEF → imm=0xFFFFFFFC, reg_a=0x1000, reg_b=0xDEADBEEF, rd_we=0.
- 0xFF9FF0EF (jal x1,-8) → imm=0xFFFFFFF8, rd_we=1. Then 0x022081B3 (mul) → illegal=1, rd_we=0.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, outputs frozen, count unchanged. out_ready=1 → next instruction appears the following cycle with no loss or duplication.
- Flush with in_valid=1 and a held bundle → next cycle out_valid=0, decode_count unchanged.
- Stream 5 back-to-back with out_ready=1 → 5 consecutive out_valid cycles. rst_n low mid-stream → out_valid=0 and count=0 immediately, asynchronously.
